// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and width helper for phase_sequencer
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ADVANCE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    // Stage index width; a single stage still gets a 1-bit index.
    function automatic int sw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/next_stage_pick.sv
// rtl/next_stage_pick.sv - rotate-priority search for the next unskipped stage
module next_stage_pick #(
    parameter int N_STAGES = 3,
    parameter int SW       = 2
) (
    input  logic [SW-1:0]       cur,
    input  logic [N_STAGES-1:0] mask,
    output logic [SW-1:0]       nxt,
    output logic                wrap,
    output logic                none_valid
);

    int best_d;

    // Distance from cur runs 1..N (cur itself is N away), so the nearest unskipped index after cur wins.
    always_comb begin
        best_d = N_STAGES + 1;
        nxt    = cur;
        for (int k = 0; k < N_STAGES; k++) begin
            int d;
            d = (k - int'(cur) + N_STAGES) % N_STAGES;
            if (d == 0) begin
                d = N_STAGES;
            end
            if (!mask[k] && (d < best_d)) begin
                best_d = d;
                nxt    = SW'(k);
            end
        end
        none_valid = (best_d == N_STAGES + 1);
        wrap       = none_valid || (nxt <= cur);
    end

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - round-robin stage sequencer with skip, watchdog, step and frame count
module phase_sequencer
    import seq_pkg::*;
#(
    parameter int N_STAGES = 3,
    parameter int TIMEOUT  = 200,
    parameter int TO_W     = 8,
    parameter int FRAME_W  = 16,
    parameter int SW       = sw_of(N_STAGES)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                run_i,
    input  logic                step_mode_i,
    input  logic                step_i,
    input  logic [N_STAGES-1:0] skip_mask_i,
    input  logic [N_STAGES-1:0] done_i,
    input  logic                clr_to_i,
    output logic [N_STAGES-1:0] en_o,
    output logic [SW-1:0]       stage_o,
    output logic                busy_o,
    output logic                frame_o,
    output logic [FRAME_W-1:0]  frame_cnt_o,
    output logic                timeout_o,
    output logic [SW-1:0]       to_stage_o
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t              state_q, state_n;
    logic [N_STAGES-1:0] en_q, en_n;
    logic [SW-1:0]       stage_q, stage_n;
    logic                frame_q, frame_n;
    logic [FRAME_W-1:0]  cnt_q, cnt_n;
    logic                to_q, to_n;
    logic [SW-1:0]       to_stage_q, to_stage_n;
    logic [TO_W-1:0]     wd_q, wd_n;

    logic [SW-1:0]       pick_cur, pick_nxt;
    logic                pick_wrap, pick_none;
    logic                done_hit;

    // From IDLE, searching after the last index yields the lowest unskipped stage.
    assign pick_cur = (state_q == ST_IDLE) ? SW'(N_STAGES - 1) : stage_q;
    // en_q is one-hot on stage_q while waiting, so this selects only the current stage's done.
    assign done_hit = |(done_i & en_q);

    next_stage_pick #(
        .N_STAGES (N_STAGES),
        .SW       (SW)
    ) u_pick (
        .cur        (pick_cur),
        .mask       (skip_mask_i),
        .nxt        (pick_nxt),
        .wrap       (pick_wrap),
        .none_valid (pick_none)
    );

    // State and output registers; reset drops any live enable at the same edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            en_q       <= '0;
            stage_q    <= '0;
            frame_q    <= 1'b0;
            cnt_q      <= '0;
            to_q       <= 1'b0;
            to_stage_q <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_n;
            en_q       <= en_n;
            stage_q    <= stage_n;
            frame_q    <= frame_n;
            cnt_q      <= cnt_n;
            to_q       <= to_n;
            to_stage_q <= to_stage_n;
            wd_q       <= wd_n;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_n    = state_q;
        en_n       = '0;
        stage_n    = stage_q;
        frame_n    = 1'b0;
        cnt_n      = cnt_q;
        to_n       = to_q;
        to_stage_n = to_stage_q;
        wd_n       = wd_q;

        if (clr_to_i) begin
            to_n       = 1'b0;
            to_stage_n = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (run_i && !pick_none) begin
                    state_n = ST_WAIT;
                    stage_n = pick_nxt;
                    en_n    = N_STAGES'(1) << pick_nxt;
                    wd_n    = '0;
                end
            end
            ST_WAIT: begin
                if (done_hit) begin
                    state_n = ST_ADVANCE;
                end else if ((TIMEOUT != 0) && (wd_q == TO_LAST)) begin
                    state_n    = ST_ADVANCE;
                    to_n       = 1'b1;
                    to_stage_n = stage_q;
                end else begin
                    en_n = en_q;
                    wd_n = wd_q + TO_W'(1);
                end
            end
            ST_ADVANCE: begin
                if (pick_wrap) begin
                    frame_n = 1'b1;
                    cnt_n   = cnt_q + FRAME_W'(1);
                end
                if (pick_none || (pick_wrap && !run_i)) begin
                    state_n = ST_IDLE;
                end else begin
                    stage_n = pick_nxt;
                    if (step_mode_i) begin
                        state_n = ST_HOLD;
                    end else begin
                        state_n = ST_WAIT;
                        en_n    = N_STAGES'(1) << pick_nxt;
                        wd_n    = '0;
                    end
                end
            end
            ST_HOLD: begin
                if (step_i || !step_mode_i) begin
                    state_n = ST_WAIT;
                    en_n    = N_STAGES'(1) << stage_q;
                    wd_n    = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign en_o        = en_q;
    assign stage_o     = stage_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign frame_o     = frame_q;
    assign frame_cnt_o = cnt_q;
    assign timeout_o   = to_q;
    assign to_stage_o  = to_stage_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - directed self-checking bench for phase_sequencer
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        step_mode;
    logic        step;
    logic [2:0]  skip_mask;
    logic [2:0]  done = '0;
    logic        clr_to;
    logic [2:0]  en_o;
    logic [1:0]  stage_o;
    logic        busy_o;
    logic        frame_o;
    logic [15:0] frame_cnt_o;
    logic        timeout_o;
    logic [1:0]  to_stage_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Responder latency per stage in cycles of en high; 0 means never answer.
    int lat [3];

    logic [2:0] prev_en = '0;
    int run_len [3];
    int last_len [3];
    int pulses [3];
    int launches [$];
    int gaps [$];
    int gap = 0;
    int frame_pulses = 0;
    int base_l;
    int base_f;
    int base_p1;

    phase_sequencer #(
        .N_STAGES (3),
        .TIMEOUT  (10),
        .TO_W     (8),
        .FRAME_W  (16)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .run_i       (run),
        .step_mode_i (step_mode),
        .step_i      (step),
        .skip_mask_i (skip_mask),
        .done_i      (done),
        .clr_to_i    (clr_to),
        .en_o        (en_o),
        .stage_o     (stage_o),
        .busy_o      (busy_o),
        .frame_o     (frame_o),
        .frame_cnt_o (frame_cnt_o),
        .timeout_o   (timeout_o),
        .to_stage_o  (to_stage_o)
    );

    always #5 clk = ~clk;

    // Stage responders plus a monitor of enable pulses, launch order, gaps and frame pulses.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (en_o[k]) begin
                run_len[k]++;
            end else if (prev_en[k]) begin
                last_len[k] = run_len[k];
                pulses[k]++;
                run_len[k] = 0;
            end
            done[k] = en_o[k] && (lat[k] != 0) && (run_len[k] >= lat[k]);
        end
        if ((en_o != 3'b000) && (en_o != prev_en)) begin
            for (int k = 0; k < 3; k++) begin
                if (en_o[k]) launches.push_back(k);
            end
            gaps.push_back(gap);
            gap = 0;
        end else if (en_o == 3'b000) begin
            gap++;
        end
        if (frame_o) frame_pulses++;
        prev_en = en_o;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target, input string tag);
        for (int i = 0; i < 300 && frame_cnt_o != 16'(target); i++) tick();
        check(tag, int'(frame_cnt_o), target);
    endtask

    task automatic wait_en(input logic [2:0] val, input string tag);
        for (int i = 0; i < 60 && en_o != val; i++) tick();
        check(tag, int'(en_o), int'(val));
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && busy_o; i++) tick();
        check(tag, int'(busy_o), 0);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; step_mode = 1'b0; step = 1'b0;
        skip_mask = 3'b000; clr_to = 1'b0;
        lat[0] = 2; lat[1] = 2; lat[2] = 2;
        repeat (3) tick();

        check("rst_en", int'(en_o), 0);
        check("rst_stage", int'(stage_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_frame", int'(frame_o), 0);
        check("rst_cnt", int'(frame_cnt_o), 0);
        check("rst_to", int'(timeout_o), 0);
        check("rst_to_stage", int'(to_stage_o), 0);
        rst_n = 1'b1;
        tick();

        // Full round, every stage answers after 2 cycles.
        base_l = launches.size(); base_f = frame_pulses;
        run = 1'b1;
        wait_frames(1, "rr_cnt");
        check("rr_l0", launches[base_l], 0);
        check("rr_l1", launches[base_l + 1], 1);
        check("rr_l2", launches[base_l + 2], 2);
        check("rr_len0", last_len[0], 2);
        check("rr_len1", last_len[1], 2);
        check("rr_len2", last_len[2], 2);
        check("rr_gap1", gaps[base_l + 1], 1);
        check("rr_gap2", gaps[base_l + 2], 1);
        check("rr_gap3", gaps[base_l + 3], 1);
        check("rr_frames", frame_pulses - base_f, 1);
        run = 1'b0;
        wait_idle("rr_idle");
        check("rr_stop_cnt", int'(frame_cnt_o), 2);

        // Stage 1 skipped for two rounds.
        skip_mask = 3'b010;
        base_l = launches.size(); base_f = frame_pulses; base_p1 = pulses[1];
        run = 1'b1;
        wait_frames(4, "sk_cnt");
        check("sk_l0", launches[base_l], 0);
        check("sk_l1", launches[base_l + 1], 2);
        check("sk_l2", launches[base_l + 2], 0);
        check("sk_l3", launches[base_l + 3], 2);
        check("sk_no_s1", pulses[1] - base_p1, 0);
        check("sk_frames", frame_pulses - base_f, 2);
        run = 1'b0;
        wait_idle("sk_idle");
        check("sk_stop_cnt", int'(frame_cnt_o), 5);
        skip_mask = 3'b000;

        // done lands on the same edge the watchdog would fire: done wins.
        lat[0] = 10;
        run = 1'b1;
        wait_frames(6, "dw_cnt");
        check("dw_len0", last_len[0], 10);
        run = 1'b0;
        wait_idle("dw_idle");
        check("dw_no_to", int'(timeout_o), 0);
        check("dw_stop_cnt", int'(frame_cnt_o), 7);
        lat[0] = 2;

        // Stage 1 never answers: watchdog forces advance after 10 cycles.
        lat[1] = 0;
        run = 1'b1;
        for (int i = 0; i < 80 && !timeout_o; i++) tick();
        check("to_set", int'(timeout_o), 1);
        check("to_stage", int'(to_stage_o), 1);
        check("to_len1", last_len[1], 10);
        run = 1'b0;
        lat[1] = 2;
        tick();
        check("to_next_en", int'(en_o), 3'b100);
        clr_to = 1'b1;
        tick();
        clr_to = 1'b0;
        check("to_clr", int'(timeout_o), 0);
        check("to_clr_stage", int'(to_stage_o), 0);
        wait_idle("to_idle");
        check("to_stop_cnt", int'(frame_cnt_o), 8);

        // Single-step: pause after stage 0 until step pulse.
        step_mode = 1'b1;
        run = 1'b1;
        wait_en(3'b001, "st_launch0");
        wait_en(3'b000, "st_done0");
        repeat (3) tick();
        check("st_hold_en", int'(en_o), 0);
        check("st_hold_busy", int'(busy_o), 1);
        check("st_hold_stage", int'(stage_o), 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("st_step_en", int'(en_o), 3'b010);
        step_mode = 1'b0;
        run = 1'b0;
        wait_idle("st_idle");
        check("st_stop_cnt", int'(frame_cnt_o), 9);

        // run dropped while stage 0 active: frame completes, then idle.
        base_l = launches.size(); base_f = frame_pulses;
        run = 1'b1;
        wait_en(3'b001, "rd_launch0");
        run = 1'b0;
        wait_idle("rd_idle");
        check("rd_nlaunch", launches.size() - base_l, 3);
        check("rd_l1", launches[base_l + 1], 1);
        check("rd_l2", launches[base_l + 2], 2);
        check("rd_frames", frame_pulses - base_f, 1);
        check("rd_cnt", int'(frame_cnt_o), 10);

        // All stages skipped: stays idle, nothing counted.
        skip_mask = 3'b111;
        run = 1'b1;
        repeat (10) tick();
        check("all_busy", int'(busy_o), 0);
        check("all_en", int'(en_o), 0);
        check("all_cnt", int'(frame_cnt_o), 10);
        skip_mask = 3'b000;

        // Reset during WAIT on stage 2 after five more frames.
        wait_frames(15, "rs_cnt15");
        wait_en(3'b100, "rs_s2");
        rst_n = 1'b0;
        tick();
        check("rs_en", int'(en_o), 0);
        check("rs_cnt", int'(frame_cnt_o), 0);
        check("rs_stage", int'(stage_o), 0);
        check("rs_busy", int'(busy_o), 0);
        rst_n = 1'b1;
        tick();
        check("rs_restart_en", int'(en_o), 3'b001);
        check("rs_restart_stage", int'(stage_o), 0);
        run = 1'b0;
        wait_idle("rs_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
